pipeline_control_unit: RTL and testbench
========================================

# pipeline_control_unit

Parametrised, stateful successor of the core's pipeline control unit. Drives per-stage stall/flush vectors, the fetch next-PC and redirect-source selects, and commit-time register-file write enable for an in-order pipeline of `NUM_STAGES` stages. Stage 0 is fetch; stage `NUM_STAGES-1` is writeback/commit. It adds a CSR/fence serialization FSM with a programmable restart window, and saturating redirect and stall-cycle performance counters.

## Interface
Parameters:
- `NUM_STAGES`, 5: pipeline stages (≥3).
- `JAL_STAGE`, 1: stage raising `dec_jal_i` (0 < JAL_STAGE < NUM_STAGES-1).
- `RESTART_CYCLES`, 1: fetch-hold cycles after a serialized instruction commits (0..15).
- `CNT_W`, 32: performance counter width.

Ports:
- `clk_i` in 1: clock.
- `rstn_i` in 1: reset. Synchronous, active-low.
- `valid_fetch_i` in 1: fetch returned a valid instruction.
- `stage_stall_req_i` in NUM_STAGES: stage k cannot advance.
- `serialize_req_i` in NUM_STAGES-1: CSR/fence instruction resident in stage k.
- `dec_jal_i` in 1: valid JAL in `JAL_STAGE`.
- `cmt_valid_i` in 1: commit stage holds a valid instruction.
- `cmt_xcpt_i`, `cmt_branch_taken_i`, `cmt_ecall_i`, `cmt_serial_i`, `cmt_write_enable_i` in 1 each: commit attributes.
- `csr_eret_i`, `csr_xcpt_i`, `csr_stall_i` in 1 each: CSR file responses.
- `stall_o` out NUM_STAGES: per-stage hold.
- `flush_o` out NUM_STAGES: per-stage invalidate.
- `next_pc_sel_o` out 2: 0=PC (hold), 1=PC+4, 2=JUMP.
- `sel_addr_if_o` out 2: 0=DECODE, 1=COMMIT, 2=CSR.
- `rf_write_enable_o` out 1: register-file write at commit.
- `serializing_o` out 1: FSM not in RUN.
- `redirect_cnt_o` out CNT_W: commit/CSR redirect count.
- `stall_cnt_o` out CNT_W: fetch-blocked cycle count.

## Operation
- Terms:
  - `csr_redir = csr_eret_i | csr_xcpt_i | (cmt_valid_i & (cmt_xcpt_i | cmt_ecall_i))`.
  - `redir = csr_redir | (cmt_valid_i & cmt_branch_taken_i)`.
- Stall: for j < NUM_STAGES-1, `stall_o[j] = csr_stall_i | OR(stage_stall_req_i[k], k ≥ j)`. `stall_o[NUM_STAGES-1] = 0`.
- Flush, evaluated in priority order:
  1. `redir`: `flush_o[NUM_STAGES-2:0]` all 1.
  2. Else state ≠ RUN, or `|serialize_req_i`, or a JAL is taken: `flush_o[0] = 1` only.
  3. `flush_o[NUM_STAGES-1]` is always 0.
  4. Flush overrides stall in the consuming stage.
- JAL taken = `dec_jal_i & !stall_o[JAL_STAGE] & state==RUN & !redir`.
- next_pc_sel_o:
  - JUMP if `redir` or JAL taken.
  - Else PC if `!valid_fetch_i | stall_o[0] | state≠RUN | |serialize_req_i`.
  - Else PC+4.
- sel_addr_if_o: CSR if `csr_redir`; else COMMIT if `cmt_valid_i & cmt_branch_taken_i`; else DECODE.
- `rf_write_enable_o = cmt_valid_i & cmt_write_enable_i & !cmt_xcpt_i & !csr_xcpt_i`.
- FSM states RUN, DRAIN, RESTART. Transitions:
  - Any state with `redir`: → RUN, restart counter cleared.
  - RUN with `|serialize_req_i`: → DRAIN.
  - DRAIN with `cmt_valid_i & cmt_serial_i`: → RESTART with counter = RESTART_CYCLES. If RESTART_CYCLES = 0, go directly to RUN.
  - RESTART: counter decrements each cycle; at 1 → RUN.
- `serializing_o = (state ≠ RUN)`.
- Counters (both saturate at all-ones, no wrap):
  - `redirect_cnt_o` +1 per cycle with `redir`.
  - `stall_cnt_o` +1 per cycle with `stall_o[0] | state≠RUN`.

## Timing
- Stall, flush, select and write-enable outputs are combinational from inputs and the registered state; zero-cycle latency.
- State and counters update on the `clk_i` edge.
- Reset (`rstn_i` = 0 sampled at edge): state=RUN, restart counter=0, counters=0.
- While `rstn_i` is low, outputs are forced regardless of inputs:
  - `flush_o[NUM_STAGES-2:0]` = all 1, `flush_o[NUM_STAGES-1]` = 0.
  - `stall_o` = 0, `next_pc_sel_o` = PC, `sel_addr_if_o` = DECODE.
  - `rf_write_enable_o` = 0, `serializing_o` = 0.
- Reset asserted mid-DRAIN/RESTART: FSM returns to RUN at the next edge.
- Redirect and serial commit in the same cycle: redirect wins, state → RUN.
- DRAIN entry cycle already holds fetch combinationally.
- RESTART_CYCLES = N gives exactly N RESTART cycles after the commit cycle.

## Test plan
- Reset: hold `rstn_i` low 3 cycles with random inputs → flush_o=5'b01111, stall_o=0, counters 0. Release → next_pc_sel_o=1 with valid_fetch_i=1.
- Stall: `stage_stall_req_i`=5'b00100 → stall_o=5'b00111, next_pc_sel_o=0, stall_cnt_o increments per cycle. Same with `dec_jal_i`=1 → JAL ignored, no flush_o[0].
- Redirects:
  - Commit taken branch → next_pc_sel_o=2, sel_addr_if_o=1, flush_o=5'b01111, redirect_cnt_o +1.
  - `csr_xcpt_i` together with `cmt_write_enable_i` → sel_addr_if_o=2, rf_write_enable_o=0.
- Serialization: `serialize_req_i[2]`=1 → DRAIN, flush_o[0]=1 and next_pc_sel_o=0 until `cmt_serial_i`. Then RESTART_CYCLES=2 gives 2 RESTART cycles, then RUN with next_pc_sel_o=1.
- Redirect during DRAIN and during RESTART → state RUN next cycle, serializing_o=0.
- Saturation: CNT_W=4, 20 redirect cycles → redirect_cnt_o holds 4'hF.

Source files
------------

// File: rtl/pipeline_control_unit.sv
// Pipeline control for an in-order pipeline: per-stage stall/flush, fetch PC and
// redirect-source selects, commit write enable, CSR/fence serialization FSM and perf counters.
module pipeline_control_unit #(
  parameter int NUM_STAGES     = 5,
  parameter int JAL_STAGE      = 1,
  parameter int RESTART_CYCLES = 1,
  parameter int CNT_W          = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  valid_fetch_i,
  input  logic [NUM_STAGES-1:0] stage_stall_req_i,
  input  logic [NUM_STAGES-2:0] serialize_req_i,
  input  logic                  dec_jal_i,
  input  logic                  cmt_valid_i,
  input  logic                  cmt_xcpt_i,
  input  logic                  cmt_branch_taken_i,
  input  logic                  cmt_ecall_i,
  input  logic                  cmt_serial_i,
  input  logic                  cmt_write_enable_i,
  input  logic                  csr_eret_i,
  input  logic                  csr_xcpt_i,
  input  logic                  csr_stall_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic [1:0]            next_pc_sel_o,
  output logic [1:0]            sel_addr_if_o,
  output logic                  rf_write_enable_o,
  output logic                  serializing_o,
  output logic [1:0]            dbg_state_o,
  output logic [CNT_W-1:0]      redirect_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RESTART = 2'd2
  } state_t;

  localparam logic [3:0] RESTART_LEN = RESTART_CYCLES[3:0];
  localparam logic [1:0] PC_HOLD = 2'd0, PC_INC = 2'd1, PC_JUMP = 2'd2;
  localparam logic [1:0] ADDR_DECODE = 2'd0, ADDR_COMMIT = 2'd1, ADDR_CSR = 2'd2;

  state_t                state_q, state_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic                  csr_redir, redir, jal_taken, any_serial, running, acc;
  logic [NUM_STAGES-1:0] stall_raw, flush_v, stall_v;

  assign csr_redir  = csr_eret_i | csr_xcpt_i | (cmt_valid_i & (cmt_xcpt_i | cmt_ecall_i));
  assign redir      = csr_redir | (cmt_valid_i & cmt_branch_taken_i);
  assign any_serial = |serialize_req_i;
  assign running    = (state_q == ST_RUN);

  // A stalled stage holds every stage behind it; commit never stalls.
  always_comb begin
    stall_raw = '0;
    acc       = 1'b0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      acc = acc | stage_stall_req_i[j];
      if (j < NUM_STAGES - 1) stall_raw[j] = csr_stall_i | acc;
    end
  end

  assign jal_taken = dec_jal_i & ~stall_raw[JAL_STAGE] & running & ~redir;

  always_comb begin
    flush_v = '0;
    if (redir) flush_v = {1'b0, {(NUM_STAGES-1){1'b1}}};
    else if (!running || any_serial || jal_taken) flush_v[0] = 1'b1;
    stall_v = stall_raw & ~flush_v;
  end

  always_comb begin
    stall_o           = stall_v;
    flush_o           = flush_v;
    next_pc_sel_o     = PC_INC;
    sel_addr_if_o     = ADDR_DECODE;
    rf_write_enable_o = cmt_valid_i & cmt_write_enable_i & ~cmt_xcpt_i & ~csr_xcpt_i;
    serializing_o     = ~running;
    if (redir || jal_taken) next_pc_sel_o = PC_JUMP;
    else if (!valid_fetch_i || stall_raw[0] || !running || any_serial) next_pc_sel_o = PC_HOLD;
    if (csr_redir) sel_addr_if_o = ADDR_CSR;
    else if (cmt_valid_i && cmt_branch_taken_i) sel_addr_if_o = ADDR_COMMIT;
    // Reset forces a quiet front end independent of the (possibly stale) state.
    if (!rstn_i) begin
      stall_o           = '0;
      flush_o           = {1'b0, {(NUM_STAGES-1){1'b1}}};
      next_pc_sel_o     = PC_HOLD;
      sel_addr_if_o     = ADDR_DECODE;
      rf_write_enable_o = 1'b0;
      serializing_o     = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (redir) begin
      state_d = ST_RUN;
      rcnt_d  = 4'd0;
    end else begin
      case (state_q)
        ST_RUN:   if (any_serial) state_d = ST_DRAIN;
        ST_DRAIN: if (cmt_valid_i && cmt_serial_i) begin
          state_d = (RESTART_LEN == 4'd0) ? ST_RUN : ST_RESTART;
          rcnt_d  = RESTART_LEN;
        end
        ST_RESTART: begin
          if (rcnt_q <= 4'd1) begin
            state_d = ST_RUN;
            rcnt_d  = 4'd0;
          end else begin
            rcnt_d = rcnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          rcnt_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q        <= ST_RUN;
      rcnt_q         <= 4'd0;
      redirect_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      if (redir && (redirect_cnt_o != {CNT_W{1'b1}})) redirect_cnt_o <= redirect_cnt_o + 1'b1;
      if ((stall_v[0] || !running) && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: a 5-stage instance with a 2-cycle restart
// window, plus a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_pipeline_control_unit;
  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       valid_fetch_i;
  logic [4:0] stage_stall_req_i;
  logic [3:0] serialize_req_i;
  logic       dec_jal_i, cmt_valid_i, cmt_xcpt_i, cmt_branch_taken_i, cmt_ecall_i;
  logic       cmt_serial_i, cmt_write_enable_i, csr_eret_i, csr_xcpt_i, csr_stall_i;

  logic [4:0]  stall_o, flush_o, s_stall_o, s_flush_o;
  logic [1:0]  next_pc_sel_o, sel_addr_if_o, dbg_state_o;
  logic [1:0]  s_next_pc_sel_o, s_sel_addr_if_o, s_dbg_state_o;
  logic        rf_write_enable_o, serializing_o, s_rf_write_enable_o, s_serializing_o;
  logic [31:0] redirect_cnt_o, stall_cnt_o;
  logic [3:0]  s_redirect_cnt_o, s_stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pipeline_control_unit #(.NUM_STAGES(5), .JAL_STAGE(1), .RESTART_CYCLES(2), .CNT_W(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_fetch_i(valid_fetch_i),
    .stage_stall_req_i(stage_stall_req_i), .serialize_req_i(serialize_req_i),
    .dec_jal_i(dec_jal_i), .cmt_valid_i(cmt_valid_i), .cmt_xcpt_i(cmt_xcpt_i),
    .cmt_branch_taken_i(cmt_branch_taken_i), .cmt_ecall_i(cmt_ecall_i),
    .cmt_serial_i(cmt_serial_i), .cmt_write_enable_i(cmt_write_enable_i),
    .csr_eret_i(csr_eret_i), .csr_xcpt_i(csr_xcpt_i), .csr_stall_i(csr_stall_i),
    .stall_o(stall_o), .flush_o(flush_o), .next_pc_sel_o(next_pc_sel_o),
    .sel_addr_if_o(sel_addr_if_o), .rf_write_enable_o(rf_write_enable_o),
    .serializing_o(serializing_o), .dbg_state_o(dbg_state_o),
    .redirect_cnt_o(redirect_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  pipeline_control_unit #(.NUM_STAGES(5), .JAL_STAGE(1), .RESTART_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_fetch_i(valid_fetch_i),
    .stage_stall_req_i(stage_stall_req_i), .serialize_req_i(serialize_req_i),
    .dec_jal_i(dec_jal_i), .cmt_valid_i(cmt_valid_i), .cmt_xcpt_i(cmt_xcpt_i),
    .cmt_branch_taken_i(cmt_branch_taken_i), .cmt_ecall_i(cmt_ecall_i),
    .cmt_serial_i(cmt_serial_i), .cmt_write_enable_i(cmt_write_enable_i),
    .csr_eret_i(csr_eret_i), .csr_xcpt_i(csr_xcpt_i), .csr_stall_i(csr_stall_i),
    .stall_o(s_stall_o), .flush_o(s_flush_o), .next_pc_sel_o(s_next_pc_sel_o),
    .sel_addr_if_o(s_sel_addr_if_o), .rf_write_enable_o(s_rf_write_enable_o),
    .serializing_o(s_serializing_o), .dbg_state_o(s_dbg_state_o),
    .redirect_cnt_o(s_redirect_cnt_o), .stall_cnt_o(s_stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_fetch_i = 1'b1;
    stage_stall_req_i = '0; serialize_req_i = '0; dec_jal_i = 1'b0;
    cmt_valid_i = 1'b0; cmt_xcpt_i = 1'b0; cmt_branch_taken_i = 1'b0; cmt_ecall_i = 1'b0;
    cmt_serial_i = 1'b0; cmt_write_enable_i = 1'b0;
    csr_eret_i = 1'b0; csr_xcpt_i = 1'b0; csr_stall_i = 1'b0;
  endtask

  initial begin
    // Reset held for 3 edges with random inputs
    rstn_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_fetch_i = 1'($urandom); stage_stall_req_i = 5'($urandom);
      serialize_req_i = 4'($urandom); dec_jal_i = 1'($urandom);
      cmt_valid_i = 1'($urandom); cmt_xcpt_i = 1'($urandom);
      cmt_branch_taken_i = 1'($urandom); cmt_ecall_i = 1'($urandom);
      cmt_serial_i = 1'($urandom); cmt_write_enable_i = 1'($urandom);
      csr_eret_i = 1'($urandom); csr_xcpt_i = 1'($urandom); csr_stall_i = 1'($urandom);
      #1;
      chk("rst_flush", flush_o, 5'b01111);
      chk("rst_stall", stall_o, 5'b00000);
      chk("rst_npc", next_pc_sel_o, 2'd0);
      chk("rst_sel", sel_addr_if_o, 2'd0);
      chk("rst_rfwe", rf_write_enable_o, 1'b0);
      chk("rst_ser", serializing_o, 1'b0);
      tick();
    end
    chk("rst_rcnt", redirect_cnt_o, 32'd0);
    chk("rst_scnt", stall_cnt_o, 32'd0);
    chk("rst_state", dbg_state_o, 2'd0);
    chk("rst_sat_rcnt", s_redirect_cnt_o, 4'd0);

    rstn_i = 1'b1;
    idle_inputs();
    #1;
    chk("run_npc", next_pc_sel_o, 2'd1);
    chk("run_flush", flush_o, 5'b00000);
    chk("run_stall", stall_o, 5'b00000);
    tick();
    chk("run_scnt", stall_cnt_o, 32'd0);

    // Stage 2 stall holds stages 0..2
    stage_stall_req_i = 5'b00100;
    #1;
    chk("stl_vec", stall_o, 5'b00111);
    chk("stl_npc", next_pc_sel_o, 2'd0);
    chk("stl_flush", flush_o, 5'b00000);
    tick();
    chk("stl_scnt1", stall_cnt_o, 32'd1);
    tick();
    chk("stl_scnt2", stall_cnt_o, 32'd2);
    dec_jal_i = 1'b1;
    #1;
    chk("stl_jal_flush", flush_o, 5'b00000);
    chk("stl_jal_npc", next_pc_sel_o, 2'd0);
    tick();
    chk("stl_scnt3", stall_cnt_o, 32'd3);

    // Unstalled JAL is taken
    stage_stall_req_i = '0;
    #1;
    chk("jal_flush", flush_o, 5'b00001);
    chk("jal_npc", next_pc_sel_o, 2'd2);
    chk("jal_stall", stall_o, 5'b00000);
    tick();
    chk("jal_scnt", stall_cnt_o, 32'd3);
    dec_jal_i = 1'b0;

    // Commit taken branch
    cmt_valid_i = 1'b1; cmt_branch_taken_i = 1'b1; cmt_write_enable_i = 1'b1;
    #1;
    chk("br_npc", next_pc_sel_o, 2'd2);
    chk("br_sel", sel_addr_if_o, 2'd1);
    chk("br_flush", flush_o, 5'b01111);
    chk("br_rfwe", rf_write_enable_o, 1'b1);
    tick();
    chk("br_rcnt", redirect_cnt_o, 32'd1);

    // CSR exception suppresses the commit write
    cmt_branch_taken_i = 1'b0; csr_xcpt_i = 1'b1;
    #1;
    chk("cx_sel", sel_addr_if_o, 2'd2);
    chk("cx_rfwe", rf_write_enable_o, 1'b0);
    chk("cx_npc", next_pc_sel_o, 2'd2);
    chk("cx_flush", flush_o, 5'b01111);
    tick();
    chk("cx_rcnt", redirect_cnt_o, 32'd2);
    idle_inputs();

    // Serialization: DRAIN until serial commit, then 2 RESTART cycles
    serialize_req_i = 4'b0100;
    #1;
    chk("ser_req_flush", flush_o, 5'b00001);
    chk("ser_req_npc", next_pc_sel_o, 2'd0);
    chk("ser_req_ser", serializing_o, 1'b0);
    tick();
    serialize_req_i = '0;
    #1;
    chk("drn_state", dbg_state_o, 2'd1);
    chk("drn_ser", serializing_o, 1'b1);
    chk("drn_flush", flush_o, 5'b00001);
    chk("drn_npc", next_pc_sel_o, 2'd0);
    chk("drn_scnt", stall_cnt_o, 32'd3);
    tick();
    chk("drn2_state", dbg_state_o, 2'd1);
    chk("drn2_scnt", stall_cnt_o, 32'd4);
    cmt_valid_i = 1'b1; cmt_serial_i = 1'b1;
    #1;
    chk("drn_cmt_flush", flush_o, 5'b00001);
    tick();
    idle_inputs();
    #1;
    chk("rs1_state", dbg_state_o, 2'd2);
    chk("rs1_npc", next_pc_sel_o, 2'd0);
    chk("rs1_scnt", stall_cnt_o, 32'd5);
    tick();
    chk("rs2_state", dbg_state_o, 2'd2);
    chk("rs2_ser", serializing_o, 1'b1);
    tick();
    chk("rs_done_state", dbg_state_o, 2'd0);
    chk("rs_done_ser", serializing_o, 1'b0);
    chk("rs_done_npc", next_pc_sel_o, 2'd1);
    chk("rs_done_flush", flush_o, 5'b00000);
    chk("rs_done_scnt", stall_cnt_o, 32'd7);

    // Redirect during DRAIN, coinciding with the serial commit
    serialize_req_i = 4'b0001;
    tick();
    serialize_req_i = '0;
    chk("rd_drn_state", dbg_state_o, 2'd1);
    cmt_valid_i = 1'b1; cmt_branch_taken_i = 1'b1; cmt_serial_i = 1'b1;
    #1;
    chk("rd_drn_npc", next_pc_sel_o, 2'd2);
    chk("rd_drn_flush", flush_o, 5'b01111);
    tick();
    idle_inputs();
    chk("rd_drn_state2", dbg_state_o, 2'd0);
    chk("rd_drn_ser", serializing_o, 1'b0);
    chk("rd_drn_rcnt", redirect_cnt_o, 32'd3);
    chk("rd_drn_scnt", stall_cnt_o, 32'd8);

    // Redirect during RESTART
    serialize_req_i = 4'b1000;
    tick();
    serialize_req_i = '0;
    cmt_valid_i = 1'b1; cmt_serial_i = 1'b1;
    tick();
    idle_inputs();
    chk("rd_rs_state", dbg_state_o, 2'd2);
    csr_eret_i = 1'b1;
    #1;
    chk("rd_rs_sel", sel_addr_if_o, 2'd2);
    tick();
    csr_eret_i = 1'b0;
    chk("rd_rs_state2", dbg_state_o, 2'd0);
    chk("rd_rs_ser", serializing_o, 1'b0);
    chk("rd_rs_rcnt", redirect_cnt_o, 32'd4);
    chk("rd_rs_scnt", stall_cnt_o, 32'd10);

    // Reset asserted mid-DRAIN
    serialize_req_i = 4'b0010;
    tick();
    serialize_req_i = '0;
    chk("mr_drn_state", dbg_state_o, 2'd1);
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    chk("mr_state", dbg_state_o, 2'd0);
    chk("mr_rcnt", redirect_cnt_o, 32'd0);
    chk("mr_scnt", stall_cnt_o, 32'd0);

    // 20 redirect cycles: 4-bit counter saturates, 32-bit counter keeps counting
    cmt_valid_i = 1'b1; cmt_branch_taken_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    idle_inputs();
    chk("sat_rcnt4", s_redirect_cnt_o, 4'hF);
    chk("sat_rcnt32", redirect_cnt_o, 32'd20);
    tick();
    chk("sat_hold", s_redirect_cnt_o, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
